accum_burst_add_sub: RTL
========================

Name: accum_burst_add_sub

Overview:
Parametrised N-bit signed/unsigned accumulator that sums a burst of LEN input samples. Each sample is added or subtracted under per-sample control.
- Input side uses a valid/ready handshake; an FSM sequences each burst.
- Result side holds the sum with a valid/ready handshake until it is consumed.
- Extends the single-register add/sub accumulator used on the board top levels. Feeds the HEX/LEDR display path or a downstream datapath.

Parameters:
N, 8, datapath width of samples and sum S
CNT_W, 8, width of burst length and sample counter (max burst 2^CNT_W-1)

Ports:
clk  input  1  clock, rising edge
aclr  input  1  reset, asynchronous, active-low
start  input  1  begin new burst (sampled only in IDLE)
len  input  CNT_W  burst length, captured on accepted start
in_valid  input  1  sample A valid
in_ready  output  1  block accepts a sample this cycle
A  input  N  sample
sub  input  1  per-sample op: 0 = S+A, 1 = S-A
out_valid  output  1  burst result valid
out_ready  input  1  consumer accepts result
S  output  N  running/final sum
carry  output  1  carry-out (add) or borrow (sub) of last applied sample
overflow  output  1  signed overflow of last applied sample
sticky_ovf  output  1  OR of overflow over the whole burst
count  output  CNT_W  number of samples accepted in current burst

Behaviour:
- Reset (aclr=0, async): state=IDLE; S, carry, overflow, sticky_ovf, count, len_r, stage regs = 0; in_ready=0; out_valid=0.
- States: IDLE, RUN, FLUSH, DONE (2-bit encoding).
- IDLE, start=1:
  - len_r<=len; S, carry, overflow, sticky_ovf, count <= 0.
  - If len==0, go to FLUSH; otherwise go to RUN.
  - start in any other state is ignored.
- RUN:
  - in_ready=1.
  - A sample is accepted on a rising edge with in_valid & in_ready. Accept registers A->B_r, sub->sub_r, vld_r<=1 (stage 1) and does count<=count+1.
  - On the edge that accepts sample number len_r, go to FLUSH.
- Stage 2: on any edge with vld_r=1, S, carry and overflow update from S and B_r; sticky_ovf |= overflow_new. vld_r clears when no sample is accepted.
- Latency: a sample accepted at edge k is reflected in S at edge k+1.
- FLUSH: in_ready=0. Lasts one cycle, letting the final stage-2 update land; then go to DONE.
- DONE:
  - out_valid=1; S and all flags are held stable.
  - On an edge with out_ready=1, go to IDLE.
  - While out_ready=0, stay in DONE indefinitely.
- Arithmetic, computed at N+1 bits:
  - add: {carry,S} = S + B_r.
  - sub: {carry,S} = S - B_r; carry=1 means borrow (S < B_r unsigned).
- overflow:
  - add: S[N-1]==B_r[N-1] && res[N-1]!=S[N-1].
  - sub: S[N-1]!=B_r[N-1] && res[N-1]!=S[N-1].
- Wrap-around: without the optional feature, S wraps modulo 2^N.
- count never exceeds len_r.
- in_valid while in_ready=0 is ignored; no sample is lost or double-counted.
- aclr asserted mid-burst clears everything immediately; the burst is abandoned and not resumed.

Optional Feature:
ACCUM_SATURATE_EN
- Defined: on signed overflow, S clamps instead of wrapping.
  - Clamp to 2^(N-1)-1 when the true result is positive, to -2^(N-1) when negative.
  - overflow and sticky_ovf still assert.
  - carry reflects the unclamped result.
- Undefined: S wraps; no clamp logic is synthesised.

Test Plan:
1. N=8: start, len=3; add 0x10, 0x20, 0x30 back-to-back -> S=0x60, carry=0, overflow=0, sticky_ovf=0, count=3. out_valid rises 2 cycles after the 3rd accept.
2. len=2: add 0x70, then add 0x20 -> overflow=1, sticky_ovf=1, carry=0. S=0x90 without ACCUM_SATURATE_EN, S=0x7F with it.
3. len=2: add 0x05, then sub 0x07 -> S=0xFE, carry(borrow)=1, overflow=0; after a further burst with no overflow, sticky_ovf=0.
4. len=0 with start -> FLUSH, then DONE with S=0x00, count=0, out_valid=1. A second start pulsed during DONE is ignored.
5. len=3 with in_valid gaps of 0/2/5 cycles; out_ready held low 5 cycles in DONE -> S=sum, out_valid stays 1 and S stable until out_ready=1, then IDLE next cycle.
6. aclr pulsed low after 2 of 4 samples -> S=0, flags=0, count=0, in_ready=0, state IDLE immediately (asynchronously); a new start then runs normally.

Source files
------------

// File: rtl/accum_burst_add_sub_if.sv
// Handshake bundle for accum_burst_add_sub: burst control, sample input and result output.
interface accum_burst_add_sub_if #(
    parameter int N     = 8,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     A;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     S;
    logic             carry;
    logic             overflow;
    logic             sticky_ovf;
    logic [CNT_W-1:0] count;

    modport master (
        output start, len, in_valid, A, sub, out_ready,
        input  in_ready, out_valid, S, carry, overflow, sticky_ovf, count
    );

    modport slave (
        input  start, len, in_valid, A, sub, out_ready,
        output in_ready, out_valid, S, carry, overflow, sticky_ovf, count
    );
endinterface

// File: rtl/accum_burst_add_sub.sv
// Burst add/sub accumulator: sums LEN samples, then holds the result until consumed.
// Define ACCUM_SATURATE_EN to clamp S on signed overflow instead of wrapping.
module accum_burst_add_sub #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  aclr,
    accum_burst_add_sub_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] len_r;
    logic [CNT_W-1:0] count_q;
    logic [N-1:0]     b_r;
    logic             sub_r;
    logic             vld_r;
    logic [N-1:0]     s_q;
    logic             carry_q;
    logic             ovf_q;
    logic             sticky_q;

    logic             accept;
    logic             start_ok;
    logic [N:0]       res;
    logic             ovf_new;
    logic [N-1:0]     s_new;

    assign accept   = bus.in_valid && (state == RUN);
    assign start_ok = bus.start && (state == IDLE);

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.start) state_nxt = (bus.len == '0) ? FLUSH : RUN;
            RUN:   if (accept && (count_q + CNT_W'(1) == len_r)) state_nxt = FLUSH;
            FLUSH: state_nxt = DONE;
            DONE:  if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 2 arithmetic at N+1 bits so the top bit is carry (add) or borrow (sub).
    always_comb begin
        res     = sub_r ? ({1'b0, s_q} - {1'b0, b_r}) : ({1'b0, s_q} + {1'b0, b_r});
        ovf_new = sub_r ? ((s_q[N-1] != b_r[N-1]) && (res[N-1] != s_q[N-1]))
                        : ((s_q[N-1] == b_r[N-1]) && (res[N-1] != s_q[N-1]));
        s_new   = res[N-1:0];
`ifdef ACCUM_SATURATE_EN
        // On overflow the true result keeps the sign of the old sum in both add and sub.
        if (ovf_new) s_new = s_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            len_r    <= '0;
            count_q  <= '0;
            b_r      <= '0;
            sub_r    <= 1'b0;
            vld_r    <= 1'b0;
            s_q      <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            vld_r <= accept;
            if (accept) begin
                b_r     <= bus.A;
                sub_r   <= bus.sub;
                count_q <= count_q + CNT_W'(1);
            end
            if (start_ok) begin
                len_r    <= bus.len;
                count_q  <= '0;
                s_q      <= '0;
                carry_q  <= 1'b0;
                ovf_q    <= 1'b0;
                sticky_q <= 1'b0;
            end else if (vld_r) begin
                s_q      <= s_new;
                carry_q  <= res[N];
                ovf_q    <= ovf_new;
                sticky_q <= sticky_q | ovf_new;
            end
        end
    end

    assign bus.in_ready   = (state == RUN);
    assign bus.out_valid  = (state == DONE);
    assign bus.S          = s_q;
    assign bus.carry      = carry_q;
    assign bus.overflow   = ovf_q;
    assign bus.sticky_ovf = sticky_q;
    assign bus.count      = count_q;
endmodule
